// File: rtl/cic_decimator.sv
// cic_decimator: multi-channel N-stage CIC decimator, 1-bit PDM in, PCM words out.
// Integrators run at the PDM strobe rate. Once per R input bits a frame token
// travels through a tap register, N comb stages and a shift/saturate output stage.
// Ports:
//   clk, reset  system clock; synchronous active-high reset
//   pdm_valid   strobe: pdm_in carries one new bit per channel
//   pdm_in      PDM bits, bit c = channel c
//   pcm_valid   pcm_data holds an undelivered sample
//   pcm_ready   consumer accepts when pcm_valid && pcm_ready
//   pcm_data    signed PCM samples, channel c at [c*OW +: OW]
//   overrun     one-cycle pulse when an unaccepted sample is overwritten
module cic_decimator #(
    parameter int unsigned CH     = 2,
    parameter int unsigned N      = 3,
    parameter int unsigned LOG2R  = 6,
    parameter int unsigned OW     = 16,
    parameter bit          INVERT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pdm_valid,
    input  logic [CH-1:0]    pdm_in,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic [CH*OW-1:0] pcm_data,
    output logic             overrun
);
    localparam int unsigned ACC_W = N * LOG2R + 2;
    localparam int unsigned SH    = N * LOG2R - OW + 1;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t ONE       = acc_t'(1);
    localparam acc_t MINUS_ONE = acc_t'(-1);
    localparam acc_t SAT_MAX   = acc_t'((1 << (OW - 1)) - 1);
    localparam acc_t SAT_MIN   = acc_t'(-(1 << (OW - 1)));

    acc_t             integ_q [CH][N];
    acc_t             integ_d [CH][N];
    acc_t             tap_q   [CH];
    acc_t             tap_d   [CH];
    acc_t             comb_q  [CH][N];
    acc_t             comb_d  [CH][N];
    acc_t             prev_q  [CH][N];
    acc_t             prev_d  [CH][N];
    acc_t             comb_x  [CH][N];
    acc_t             shifted [CH];
    logic [LOG2R-1:0] phase_q, phase_d;
    logic             frame_q, frame_d;
    logic [N:0]       tok_q, tok_d;
    logic [CH*OW-1:0] pcm_data_q, pcm_data_d;
    logic             pcm_valid_q, pcm_valid_d;
    logic             overrun_q, overrun_d;

    // Comb stage inputs (tap feeds stage 0) and the scaled output of the last comb.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            comb_x[c][0] = tap_q[c];
            for (int k = 1; k < N; k++) begin
                comb_x[c][k] = comb_q[c][k-1];
            end
            shifted[c] = comb_q[c][N-1] >>> SH;
        end
    end

    // Next-state logic for integrators, decimation, comb pipe and output handshake.
    always_comb begin
        integ_d     = integ_q;
        tap_d       = tap_q;
        comb_d      = comb_q;
        prev_d      = prev_q;
        phase_d     = phase_q;
        frame_d     = 1'b0;
        tok_d       = {tok_q[N-1:0], frame_q};
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = pcm_valid_q && !pcm_ready;
        overrun_d   = 1'b0;

        if (pdm_valid) begin
            phase_d = phase_q + LOG2R'(1);
            frame_d = &phase_q;
            for (int c = 0; c < CH; c++) begin
                integ_d[c][0] = integ_q[c][0] + ((pdm_in[c] ^ INVERT) ? ONE : MINUS_ONE);
                // Each later stage accumulates the previous stage's registered value.
                for (int k = 1; k < N; k++) begin
                    integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
                end
            end
        end

        if (frame_q) begin
            for (int c = 0; c < CH; c++) begin
                tap_d[c] = integ_q[c][N-1];
            end
        end

        for (int k = 0; k < N; k++) begin
            if (tok_q[k]) begin
                for (int c = 0; c < CH; c++) begin
                    comb_d[c][k] = comb_x[c][k] - prev_q[c][k];
                    prev_d[c][k] = comb_x[c][k];
                end
            end
        end

        if (tok_q[N]) begin
            pcm_valid_d = 1'b1;
            overrun_d   = pcm_valid_q && !pcm_ready;
            for (int c = 0; c < CH; c++) begin
                if (shifted[c] > SAT_MAX) begin
                    pcm_data_d[c*OW +: OW] = OW'(SAT_MAX);
                end else if (shifted[c] < SAT_MIN) begin
                    pcm_data_d[c*OW +: OW] = OW'(SAT_MIN);
                end else begin
                    pcm_data_d[c*OW +: OW] = OW'(shifted[c]);
                end
            end
        end
    end

    // State registers; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                tap_q[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    integ_q[c][k] <= '0;
                    comb_q[c][k]  <= '0;
                    prev_q[c][k]  <= '0;
                end
            end
            phase_q     <= '0;
            frame_q     <= 1'b0;
            tok_q       <= '0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            tap_q       <= tap_d;
            comb_q      <= comb_d;
            prev_q      <= prev_d;
            phase_q     <= phase_d;
            frame_q     <= frame_d;
            tok_q       <= tok_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pcm_data  = pcm_data_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule
